// File: rtl/grid_ctrl_pkg.sv
// grid_ctrl_pkg: state encoding and load-select constants shared by the
// grid step controller and the cell-array wrappers.
package grid_ctrl_pkg;
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_STEP   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;
    localparam logic SEL_INIT = 1'b0;
    localparam logic SEL_NEXT = 1'b1;
endpackage

// File: rtl/grid_step_controller_settle_timer.sv
// settle_timer: loadable down-counter with hold and zero flag.
module settle_timer #(
    parameter int W = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         hold,
    output logic         zero
);
    logic [W-1:0] count;
    always_ff @(posedge Clk or posedge Reset)
        if (Reset) count <= '0;
        else if (load) count <= load_val;
        else if (!hold && count != '0) count <= count - 1'b1;
    assign zero = count == '0;
endmodule

// File: rtl/grid_step_controller.sv
// grid_step_controller: sequences one INIT load tick then num_gens NEXT update
// ticks for the cell array, each update preceded by a settle window.
module grid_step_controller
    import grid_ctrl_pkg::*;
#(
    parameter int GEN_W         = 8,
    parameter int SETTLE_CYCLES = 2,
    parameter int SETTLE_W      = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [GEN_W-1:0] num_gens,
    input  logic             pause,
    input  logic             abort,
    output logic             cell_tick,
    output logic             sel_next,
    output logic             busy,
    output logic             done,
    output logic [GEN_W-1:0] gen_count
);
    logic [2:0]       state, state_n;
    logic [GEN_W-1:0] target;
    logic             accept, last, zero;
    assign accept = start && (state == ST_IDLE || state == ST_DONE);
    assign last   = gen_count + GEN_W'(1) == target;
    // Reloading in LOAD/STEP is harmless when the next state is DONE.
    settle_timer #(.W(SETTLE_W)) u_timer (
        .Clk      (Clk),
        .Reset    (Reset),
        .load     (state == ST_LOAD || state == ST_STEP),
        .load_val (SETTLE_W'(SETTLE_CYCLES - 1)),
        .hold     (state != ST_SETTLE || pause),
        .zero     (zero)
    );
    assign state_n = abort                ? ST_IDLE :
                     accept               ? ST_LOAD :
                     state == ST_LOAD     ? (target == '0 ? ST_DONE : ST_SETTLE) :
                     state == ST_SETTLE   ? (zero && !pause ? ST_STEP : ST_SETTLE) :
                     state == ST_STEP     ? (last ? ST_DONE : ST_SETTLE) :
                     state == ST_DONE     ? ST_DONE : ST_IDLE;
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= ST_IDLE;
            target    <= '0;
            gen_count <= '0;
        end else begin
            state <= state_n;
            if (abort) gen_count <= '0;
            else if (accept) begin
                target    <= num_gens;
                gen_count <= '0;
            end else if (state == ST_STEP) gen_count <= gen_count + 1'b1;
        end
    end
    assign cell_tick = state == ST_LOAD || state == ST_STEP;
    assign sel_next  = (state == ST_SETTLE || state == ST_STEP || state == ST_DONE) ? SEL_NEXT : SEL_INIT;
    assign busy      = state == ST_LOAD || state == ST_SETTLE || state == ST_STEP;
    assign done      = state == ST_DONE;
endmodule
